// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges memory wait, multi-cycle EX ops,
// load-use hazards and taken branches into per-register hold/bubble controls.
module pipeline_hazard_ctrl #(
  parameter int MULDIV_LAT  = 32,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_ex_hazard,
  input  logic             branch_taken,
  input  logic             ex_multi_start,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             stall_idex,
  output logic             stall_exmem,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             flush_memwb,
  output logic             ex_multi_busy,
  output logic             ex_multi_done,
  output logic             dmem_timeout,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
);

  localparam int MW = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT - 1) : 1;
  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit MULTI_EN = (MULDIV_LAT > 1);
  localparam logic [MW-1:0] MUL_LOAD  = MW'((MULDIV_LAT > 1) ? (MULDIV_LAT - 2) : 0);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  typedef enum logic {ST_RUN = 1'b0, ST_MULTI = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [MW-1:0]    mul_cnt_q, mul_cnt_d;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic waiting_s, timeout_s, mem_wait_s, branch_act_s;
  logic st_pc_s, st_ifid_s, st_idex_s, st_exmem_s;
  logic fl_ifid_s, fl_idex_s, fl_exmem_s, fl_memwb_s;
  logic busy_s, done_s;

  // Hazard arbitration and FSM next state; memory wait freezes everything else.
  always_comb begin
    state_d      = state_q;
    mul_cnt_d    = mul_cnt_q;
    st_pc_s      = 1'b0;
    st_ifid_s    = 1'b0;
    st_idex_s    = 1'b0;
    st_exmem_s   = 1'b0;
    fl_ifid_s    = 1'b0;
    fl_idex_s    = 1'b0;
    fl_exmem_s   = 1'b0;
    fl_memwb_s   = 1'b0;
    busy_s       = 1'b0;
    done_s       = 1'b0;
    branch_act_s = 1'b0;
    waiting_s    = dmem_req & ~dmem_ack;
    timeout_s    = waiting_s & (wait_cnt_q == WAIT_LAST);
    mem_wait_s   = waiting_s & ~timeout_s;
    wait_cnt_d   = mem_wait_s ? (wait_cnt_q + WW'(1)) : '0;

    if (mem_wait_s) begin
      st_pc_s    = 1'b1;
      st_ifid_s  = 1'b1;
      st_idex_s  = 1'b1;
      st_exmem_s = 1'b1;
      fl_memwb_s = 1'b1;
      busy_s     = (state_q == ST_MULTI);
    end else begin
      case (state_q)
        ST_MULTI: begin
          if (mul_cnt_q == '0) begin
            done_s  = 1'b1;
            state_d = ST_RUN;
          end else begin
            st_pc_s    = 1'b1;
            st_ifid_s  = 1'b1;
            st_idex_s  = 1'b1;
            fl_exmem_s = 1'b1;
            busy_s     = 1'b1;
            mul_cnt_d  = mul_cnt_q - MW'(1);
          end
        end
        ST_RUN: begin
          if (mem_ex_hazard) begin
            st_pc_s    = 1'b1;
            st_ifid_s  = 1'b1;
            st_idex_s  = 1'b1;
            fl_exmem_s = 1'b1;
          end else if (ex_multi_start) begin
            // A single-cycle "multi" op completes in place without a bubble.
            if (MULTI_EN) begin
              st_pc_s    = 1'b1;
              st_ifid_s  = 1'b1;
              st_idex_s  = 1'b1;
              fl_exmem_s = 1'b1;
              busy_s     = 1'b1;
              mul_cnt_d  = MUL_LOAD;
              state_d    = ST_MULTI;
            end else begin
              done_s = 1'b1;
            end
          end else if (branch_taken) begin
            fl_ifid_s    = 1'b1;
            fl_idex_s    = 1'b1;
            branch_act_s = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d   = ST_RUN;
          mul_cnt_d = '0;
        end
      endcase
    end

    stall_cnt_d = st_pc_s ? (stall_cnt_q + CNT_W'(1)) : stall_cnt_q;
    flush_cnt_d = branch_act_s ? (flush_cnt_q + CNT_W'(1)) : flush_cnt_q;
  end

  // State, wait watchdog and performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      mul_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mul_cnt_q   <= mul_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Controls are forced low while reset is held, whatever the inputs do.
  assign stall_pc       = rst_n & st_pc_s;
  assign stall_ifid     = rst_n & st_ifid_s;
  assign stall_idex     = rst_n & st_idex_s;
  assign stall_exmem    = rst_n & st_exmem_s;
  assign flush_ifid     = rst_n & fl_ifid_s;
  assign flush_idex     = rst_n & fl_idex_s;
  assign flush_exmem    = rst_n & fl_exmem_s;
  assign flush_memwb    = rst_n & fl_memwb_s;
  assign ex_multi_busy  = rst_n & busy_s;
  assign ex_multi_done  = rst_n & done_s;
  assign dmem_timeout   = rst_n & timeout_s;
  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: two instances (LAT=4/TO=8/32-bit counters and
// LAT=1/TO=3/8-bit counters) checked every cycle against a cycle-count reference model.
module tb_pipeline_hazard_ctrl;

  localparam int SP = 10, SI = 9, SX = 8, SM = 7, FI = 6, FX = 5, FM = 4, FW = 3;
  localparam int BZ = 2, DN = 1, TM = 0;

  typedef struct {
    int     ex_left;
    int     waited;
    longint stalls;
    longint flushes;
  } mstate_t;

  typedef struct packed {
    logic [10:0] f;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hz = 1'b1, br = 1'b1, st = 1'b1, rq = 1'b1, ak = 1'b1;

  logic a_sp, a_si, a_sx, a_sm, a_fi, a_fx, a_fm, a_fw, a_bz, a_dn, a_tm;
  logic b_sp, b_si, b_sx, b_sm, b_fi, b_fx, b_fm, b_fw, b_bz, b_dn, b_tm;
  logic [31:0] a_sc, a_fc;
  logic [7:0]  b_sc, b_fc;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;
  exp_t q0[$];
  exp_t q1[$];
  mstate_t m0, m1;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MULDIV_LAT(4), .MEM_TIMEOUT(8), .CNT_W(32)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .mem_ex_hazard(hz), .branch_taken(br), .ex_multi_start(st),
    .dmem_req(rq), .dmem_ack(ak),
    .stall_pc(a_sp), .stall_ifid(a_si), .stall_idex(a_sx), .stall_exmem(a_sm),
    .flush_ifid(a_fi), .flush_idex(a_fx), .flush_exmem(a_fm), .flush_memwb(a_fw),
    .ex_multi_busy(a_bz), .ex_multi_done(a_dn), .dmem_timeout(a_tm),
    .perf_stall_cnt(a_sc), .perf_flush_cnt(a_fc)
  );

  pipeline_hazard_ctrl #(.MULDIV_LAT(1), .MEM_TIMEOUT(3), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mem_ex_hazard(hz), .branch_taken(br), .ex_multi_start(st),
    .dmem_req(rq), .dmem_ack(ak),
    .stall_pc(b_sp), .stall_ifid(b_si), .stall_idex(b_sx), .stall_exmem(b_sm),
    .flush_ifid(b_fi), .flush_idex(b_fx), .flush_exmem(b_fm), .flush_memwb(b_fw),
    .ex_multi_busy(b_bz), .ex_multi_done(b_dn), .dmem_timeout(b_tm),
    .perf_stall_cnt(b_sc), .perf_flush_cnt(b_fc)
  );

  // Reference: ex_left = EX cycles still owed by the multi-cycle op, waited = dmem wait run.
  task automatic model_step(inout mstate_t s, input int lat, input int tmo_lim, input int cw,
                            output exp_t e);
    logic waiting, tmo, mw;
    logic [10:0] f;
    longint m;
    m = (longint'(1) << cw) - 1;
    f = '0;
    e.sc = 32'(s.stalls);
    e.fc = 32'(s.flushes);
    if (!rst_n) begin
      s.ex_left = 0; s.waited = 0; s.stalls = 0; s.flushes = 0;
      e.sc = '0; e.fc = '0;
    end else begin
      waiting = rq && !ak;
      tmo = waiting && (s.waited == tmo_lim - 1);
      mw = waiting && !tmo;
      if (mw) begin
        f[SP] = 1'b1; f[SI] = 1'b1; f[SX] = 1'b1; f[SM] = 1'b1; f[FW] = 1'b1;
        f[BZ] = (s.ex_left > 0);
        s.waited++;
      end else begin
        s.waited = 0;
        f[TM] = tmo;
        if (s.ex_left == 1) begin
          f[DN] = 1'b1;
          s.ex_left = 0;
        end else if (s.ex_left > 1) begin
          f[SP] = 1'b1; f[SI] = 1'b1; f[SX] = 1'b1; f[FM] = 1'b1; f[BZ] = 1'b1;
          s.ex_left--;
        end else if (hz) begin
          f[SP] = 1'b1; f[SI] = 1'b1; f[SX] = 1'b1; f[FM] = 1'b1;
        end else if (st) begin
          if (lat == 1) f[DN] = 1'b1;
          else begin
            f[SP] = 1'b1; f[SI] = 1'b1; f[SX] = 1'b1; f[FM] = 1'b1; f[BZ] = 1'b1;
            s.ex_left = lat - 1;
          end
        end else if (br) begin
          f[FI] = 1'b1; f[FX] = 1'b1;
          s.flushes = (s.flushes + 1) & m;
        end
      end
      if (f[SP]) s.stalls = (s.stalls + 1) & m;
    end
    e.f = f;
  endtask

  task automatic cyc(input logic r, input logic h, input logic b, input logic s,
                     input logic q, input logic a);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r; hz = h; br = b; st = s; rq = q; ak = a;
    model_step(m0, 4, 8, 32, e);
    q0.push_back(e);
    model_step(m1, 1, 3, 8, e);
    q1.push_back(e);
  endtask

  // Monitor: one expected response per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e, act;
    if (q0.size() > 0 && q1.size() > 0) begin
      cyc_n++;
      e = q0.pop_front();
      act = {a_sp, a_si, a_sx, a_sm, a_fi, a_fx, a_fm, a_fw, a_bz, a_dn, a_tm, a_sc, a_fc};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL lat4_outputs cyc=%0d got flags=%b sc=%0d fc=%0d, expected flags=%b sc=%0d fc=%0d",
                 cyc_n, act.f, act.sc, act.fc, e.f, e.sc, e.fc);
      end
      e = q1.pop_front();
      act = {b_sp, b_si, b_sx, b_sm, b_fi, b_fx, b_fm, b_fw, b_bz, b_dn, b_tm,
             24'd0, b_sc, 24'd0, b_fc};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL lat1_outputs cyc=%0d got flags=%b sc=%0d fc=%0d, expected flags=%b sc=%0d fc=%0d",
                 cyc_n, act.f, act.sc, act.fc, e.f, e.sc, e.fc);
      end
    end
  end

  initial begin
    int ack_pct;
    m0 = '{0, 0, 0, 0};
    m1 = '{0, 0, 0, 0};
    // reset with every input high, then clean release
    repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // single load-use bubble
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // multi-cycle op held for its full latency
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // memory wait of 5 cycles while the multi op is mid-flight
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // watchdog: request never acknowledged
    repeat (18) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // branch blocked by load-use, then taken
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // reset in the middle of a multi op and of a memory wait
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // random traffic, alternating between responsive and sluggish memory
    for (int i = 0; i < 4000; i++) begin
      ack_pct = ((i / 400) % 2 == 0) ? 60 : 8;
      cyc(($urandom_range(0, 299) != 0),
          ($urandom_range(0, 99) < 20),
          ($urandom_range(0, 99) < 30),
          ($urandom_range(0, 99) < 25),
          ($urandom_range(0, 99) < 40),
          ($urandom_range(0, 99) < ack_pct));
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d/%0d pending, expected 0/0", q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
